inv_sub_bytes_seq: RTL and testbench
====================================

# inv_sub_bytes_seq

- Iterative InvSubBytes stage for the AES decryption round datapath.
- Accepts one 128-bit state on a valid/ready handshake.
- Substitutes all 16 bytes through `LANES` instances of the `inv_sbox` byte lookup over `16/LANES` cycles.
- Presents the result on a valid/ready handshake.
- Sits between InvShiftRows (upstream) and AddRoundKey (downstream).

## Interface
Parameters:
- `LANES`, default 4: bytes substituted per cycle.
  - Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- `N = 16/LANES` is derived, not overridable. It is the number of substitution cycles.

Ports. One clock; reset is asynchronous and active-low.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: upstream has a state on `in_state`.
- `in_ready` output 1: block can accept a state.
- `in_state` input 128: input state. Byte 0 = [127:120] … byte 15 = [7:0].
- `out_valid` output 1: `out_state` holds a completed result.
- `out_ready` input 1: downstream accepts the result.
- `out_state` output 128: substituted state, same byte order as `in_state`.
- `busy` output 1: high in RUN or DONE.

## Operation
Registers:
- 128-bit work register `work`, driving `out_state`.
- Group counter `cnt`, width max(1, clog2(N)).
- FSM with states IDLE, RUN, DONE.

States:
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: `work` <= `in_state`, `cnt` <= 0, go to RUN.
- **RUN**
  - `in_ready`=0.
  - Each cycle, bytes `cnt*LANES` … `cnt*LANES+LANES-1` of `work` are replaced by their `inv_sbox` outputs. Other bytes hold.
  - If `cnt` = N-1, go to DONE. Otherwise `cnt` <= `cnt`+1.
- **DONE**
  - `out_valid`=1, `in_ready`=0. `work` holds.
  - On `out_ready`, go to IDLE.

Other rules:
- Lane i of the `inv_sbox` instances always sees byte `cnt*LANES+i` of `work`. The lookup is combinational.
- `in_valid` outside IDLE is ignored; no capture.
- `out_state` is meaningful only while `out_valid`=1. It must not change while `out_valid`=1 and `out_ready`=0.
- `LANES`=16, N=1: RUN lasts exactly one cycle.

## Timing
Reset values, asynchronous:
- FSM = IDLE, `cnt`=0, `work`=0.
- Therefore `in_ready`=1, `out_valid`=0, `busy`=0, `out_state`=0.

Reset mid-operation, in RUN or DONE:
- Immediate return to the values above.
- The in-flight state is discarded, and no `out_valid` pulse is produced.

Latency and throughput:
- Accept on edge E. `out_valid` rises after edge E+N (E+4 at default).
- With `out_ready` held high, the result is consumed on edge E+N+1 and `in_ready` is high again after it.
- Sustained throughput is one block per N+2 cycles. There is no overlap of accept and deliver.

Handshake:
- A transfer occurs on any edge where valid and ready are both 1.
- `in_ready` and `out_valid` are pure functions of the FSM state. There is no combinational path from `out_ready` or `in_valid` to any output.

Backpressure:
- `out_ready`=0 holds DONE indefinitely.
- `in_ready` stays 0 throughout.

## Structure
Shared package `aes_pkg` holds:
- `AES_BLOCK_W`=128 and `AES_NBYTES`=16.
- The FSM state enum (IDLE, RUN, DONE).
- A byte-index helper function (byte k = bits [127-8k -: 8]).

Sub-module:
- Reuse the existing `inv_sbox` (8-bit in, 8-bit out, combinational), instantiated `LANES` times in a generate loop.
- No new sub-module.

## Test plan
1. **Reset.** Assert `rst_n`=0 mid-RUN.
   - Required: `in_ready`=1, `out_valid`=0, `out_state`=0 immediately.
   - Required: no later `out_valid`.
2. **Known vector, LANES=4.** `in_state`=0x00112233445566778899aabbccddeeff with `out_ready`=1.
   - Required: `out_state`=0x52e3946686edd30297f962fe27c9997d.
   - Required: `out_valid` high exactly 4 cycles after the accept edge, for 1 cycle.
3. **Edge bytes.**
   - All bytes 0x63 → all 0x00.
   - All bytes 0xff → all 0x7d.
   - All bytes 0x00 → all 0x52.
4. **Backpressure.** Hold `out_ready`=0 for 10 cycles in DONE while driving `in_valid`=1 with a new state.
   - Required: `out_state` stable and `in_ready`=0 throughout.
   - Required: the second state is accepted only after `out_ready`=1 and the return to IDLE.
5. **Parameter sweep.** LANES ∈ {1, 2, 8, 16} with vector 2.
   - Required: identical `out_state`.
   - Required: latency 16, 8, 2, 1 cycles respectively.
6. **Back-to-back random.** 1000 random states with random `in_valid`/`out_ready` gaps.
   - Required: each output equals the byte-wise inverse S-box of its input.
   - Required: in order, none lost, none duplicated.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, FSM state encoding and byte helpers.
// Byte k of a block occupies bits [127-8k -: 8] (byte 0 is the MSB byte).
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Extract byte k of a block.
    function automatic logic [7:0] get_byte(input logic [AES_BLOCK_W-1:0] s,
                                            input int unsigned             k);
        logic [AES_BLOCK_W-1:0] t;
        t = s << (8 * k);
        return t[AES_BLOCK_W-1 -: 8];
    endfunction

    // Return a copy of the block with byte k replaced by b.
    function automatic logic [AES_BLOCK_W-1:0] put_byte(input logic [AES_BLOCK_W-1:0] s,
                                                        input int unsigned             k,
                                                        input logic [7:0]              b);
        int unsigned sh;
        sh = 8 * (AES_NBYTES - 1 - k);
        return (s & ~({{(AES_BLOCK_W-8){1'b0}}, 8'hFF} << sh))
             | ({{(AES_BLOCK_W-8){1'b0}}, b} << sh);
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box: combinational 8-bit table lookup.
module inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative InvSubBytes: captures a 128-bit state, substitutes LANES bytes
// per cycle through inv_sbox lanes over 16/LANES cycles, then holds the
// result until the downstream stage accepts it.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int N  = AES_NBYTES / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [127:0]   r_work;
    logic [127:0]   w_work_sub;
    logic [31:0]    w_base;
    logic [7:0]     w_lane_in  [LANES];
    logic [7:0]     w_lane_out [LANES];

    assign w_base    = 32'(r_cnt) * 32'(LANES);
    assign out_state = r_work;

    // Lane gi always looks at byte cnt*LANES+gi of the work register.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_lane_in[gi] = get_byte(r_work, w_base + 32'(gi));
        inv_sbox u_inv_sbox (
            .i_byte (w_lane_in[gi]),
            .o_byte (w_lane_out[gi])
        );
    end

    // Work register with the current byte group replaced by the lane outputs.
    always_comb begin
        w_work_sub = r_work;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_work_sub = put_byte(w_work_sub, w_base + i, w_lane_out[i]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and handshake outputs; outputs depend only on the state.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == CNT_LAST) w_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture in IDLE, substitute one group per cycle in RUN, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work <= in_state;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_work <= w_work_sub;
                    if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed and random checks of inv_sub_bytes_seq: reset, known vectors,
// edge bytes, backpressure, LANES sweep and a randomised stream checked
// against a forward S-box built from GF(2^8) arithmetic.
module tb_inv_sub_bytes_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    logic         s_in_valid;
    logic [127:0] s_in_state;
    logic         s_out_ready;
    logic         s_in_ready  [4];
    logic         s_out_valid [4];
    logic [127:0] s_out_state [4];
    logic         s_busy      [4];

    int errors = 0;
    int checks = 0;

    logic [7:0] fsb [256];

    localparam logic [127:0] V_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V_OUT = 128'h52e3946686edd30297f962fe27c9997d;

    inv_sub_bytes_seq #(.LANES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .busy(busy)
    );

    inv_sub_bytes_seq #(.LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[0]),
        .in_state(s_in_state), .out_valid(s_out_valid[0]), .out_ready(s_out_ready),
        .out_state(s_out_state[0]), .busy(s_busy[0])
    );
    inv_sub_bytes_seq #(.LANES(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[1]),
        .in_state(s_in_state), .out_valid(s_out_valid[1]), .out_ready(s_out_ready),
        .out_state(s_out_state[1]), .busy(s_busy[1])
    );
    inv_sub_bytes_seq #(.LANES(8)) u_l8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[2]),
        .in_state(s_in_state), .out_valid(s_out_valid[2]), .out_ready(s_out_ready),
        .out_state(s_out_state[2]), .busy(s_busy[2])
    );
    inv_sub_bytes_seq #(.LANES(16)) u_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[3]),
        .in_state(s_in_state), .out_valid(s_out_valid[3]), .out_ready(s_out_ready),
        .out_state(s_out_state[3]), .busy(s_busy[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] fwd_calc(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        if (a == 8'h00) r = 8'h00;
        else for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] fwd_block(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = fsb[s[127-8*k -: 8]];
        return r;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present a state for one accept edge (DUT must be in IDLE).
    task automatic send(input logic [127:0] s);
        in_state = s;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        int slat [4];
        logic [127:0] sres [4];
        logic [127:0] edge_in  [3];
        logic [127:0] edge_out [3];
        logic [127:0] q [$];
        int sent, recv, cyc;
        logic acc;

        for (int a = 0; a < 256; a++) fsb[a] = fwd_calc(8'(a));

        rst_n = 1'b0; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_state = '0; s_out_ready = 1'b1;
        #12;
        chk("reset_in_ready",  {127'b0, in_ready},  128'd1);
        chk("reset_out_valid", {127'b0, out_valid}, 128'd0);
        chk("reset_busy",      {127'b0, busy},      128'd0);
        chk("reset_out_state", out_state,           128'd0);
        step();
        rst_n = 1'b1;
        step();

        // Known vector, latency and one-cycle pulse.
        out_ready = 1'b1;
        send(V_IN);
        wait_valid(lat);
        chk("known_latency", 128'(lat), 128'd4);
        chk("known_state",   out_state, V_OUT);
        step();
        chk("known_pulse_end", {127'b0, out_valid}, 128'd0);
        chk("known_ready_back", {127'b0, in_ready}, 128'd1);

        // Edge bytes.
        edge_in[0] = {16{8'h63}}; edge_out[0] = {16{8'h00}};
        edge_in[1] = {16{8'hff}}; edge_out[1] = {16{8'h7d}};
        edge_in[2] = {16{8'h00}}; edge_out[2] = {16{8'h52}};
        for (int v = 0; v < 3; v++) begin
            send(edge_in[v]);
            wait_valid(lat);
            chk($sformatf("edge_state_%0d", v), out_state, edge_out[v]);
            step();
        end

        // Reset asserted mid-RUN.
        send(V_IN);
        step();
        chk("midrun_busy_before", {127'b0, busy}, 128'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun_in_ready",  {127'b0, in_ready},  128'd1);
        chk("midrun_out_valid", {127'b0, out_valid}, 128'd0);
        chk("midrun_out_state", out_state,           128'd0);
        chk("midrun_busy",      {127'b0, busy},      128'd0);
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (out_valid) seen = 1;
        end
        chk("midrun_no_late_valid", 128'(seen), 128'd0);

        // Backpressure: hold DONE while a second state waits.
        out_ready = 1'b0;
        send(V_IN);
        wait_valid(lat);
        chk("bp_latency", 128'(lat), 128'd4);
        in_state = {16{8'hff}};
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_state_hold", out_state, V_OUT);
            chk("bp_in_ready",   {127'b0, in_ready},  128'd0);
            chk("bp_out_valid",  {127'b0, out_valid}, 128'd1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_back_idle", {127'b0, in_ready}, 128'd1);
        chk("bp_drained",   {127'b0, out_valid}, 128'd0);
        step();
        in_valid = 1'b0;
        chk("bp_second_accepted", {127'b0, busy}, 128'd1);
        wait_valid(lat);
        chk("bp_second_latency", 128'(lat), 128'd4);
        chk("bp_second_state",   out_state, {16{8'h7d}});
        step();

        // LANES sweep: 1, 2, 8, 16.
        s_in_state = V_IN;
        s_in_valid = 1'b1;
        step();
        s_in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin slat[j] = 0; sres[j] = '0; end
        for (int c = 1; c <= 24; c++) begin
            step();
            for (int j = 0; j < 4; j++) begin
                if (s_out_valid[j] && slat[j] == 0) begin
                    slat[j] = c;
                    sres[j] = s_out_state[j];
                end
            end
        end
        chk("sweep_lat_l1",  128'(slat[0]), 128'd16);
        chk("sweep_lat_l2",  128'(slat[1]), 128'd8);
        chk("sweep_lat_l8",  128'(slat[2]), 128'd2);
        chk("sweep_lat_l16", 128'(slat[3]), 128'd1);
        for (int j = 0; j < 4; j++) chk($sformatf("sweep_state_%0d", j), sres[j], V_OUT);

        // Random stream with random gaps on both sides.
        sent = 0; recv = 0; cyc = 0;
        in_valid = 1'b0;
        while (recv < 1000 && cyc < 50000) begin
            if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(in_state);
                sent++;
            end
            if (out_valid && out_ready) begin
                recv++;
                if (q.size() == 0) chk("rand_spurious_out", {127'b0, out_valid}, 128'd0);
                else chk("rand_data", fwd_block(out_state), q.pop_front());
            end
            step();
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand_received", 128'(recv), 128'd1000);
        chk("rand_none_left", 128'(q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
